// File: rtl/pattern_ser_tx_if.sv
// pattern_ser_tx_if: frame load, stall, counter clear and serial output bundle for pattern_ser_tx
//   data_i/load_i/hold_i/clr_cnt_i   driven by the master towards the transmitter
//   ready_o/d_o/valid_o/done_o/pat_cnt_o driven by the transmitter (slave)
interface pattern_ser_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] data_i;
  logic             load_i;
  logic             ready_o;
  logic             hold_i;
  logic             clr_cnt_i;
  logic             d_o;
  logic             valid_o;
  logic             done_o;
  logic [CNT_W-1:0] pat_cnt_o;
  modport master (
    output data_i, load_i, hold_i, clr_cnt_i,
    input  ready_o, d_o, valid_o, done_o, pat_cnt_o
  );
  modport slave (
    input  data_i, load_i, hold_i, clr_cnt_i,
    output ready_o, d_o, valid_o, done_o, pat_cnt_o
  );
endinterface

// File: rtl/pattern_ser_tx.sv
// pattern_ser_tx: MSB-first frame serializer with stall, done pulse and saturating overlapping-1011 counter
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  pattern_ser_tx_if.slave (data_i, load_i, hold_i, clr_cnt_i in; ready_o, d_o, valid_o, done_o, pat_cnt_o out)
module pattern_ser_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  pattern_ser_tx_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic             d_q, d_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [2:0]       hist_q, hist_d;
  logic [CNT_W-1:0] pat_q, pat_d;
  // bits_q counts the bits still owed including the one on d_o, so the
  // acceptance edge already presents the MSB and a count of one means the
  // next unstalled edge ends the frame.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    d_d     = d_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.load_i) begin
        state_d = SEND;
        d_d     = bus.data_i[WIDTH-1];
        shift_d = bus.data_i << 1;
        bits_d  = BW'(WIDTH);
        valid_d = 1'b1;
      end
    end else if (!bus.hold_i) begin
      if (bits_q == BW'(1)) begin
        state_d = IDLE;
        d_d     = 1'b0;
        shift_d = '0;
        bits_d  = '0;
        done_d  = 1'b1;
      end else begin
        d_d     = shift_q[WIDTH-1];
        shift_d = shift_q << 1;
        bits_d  = bits_q - BW'(1);
        valid_d = 1'b1;
      end
    end
  end
  // The history only advances on bits actually driven, so hold cycles and
  // inter-frame gaps are transparent to pattern detection.
  always_comb begin
    hist_d = hist_q;
    pat_d  = pat_q;
    if (bus.clr_cnt_i) begin
      hist_d = '0;
      pat_d  = '0;
    end else if (valid_d) begin
      hist_d = {hist_q[1:0], d_d};
      pat_d  = (d_d && hist_q == 3'b101 && pat_q != '1) ? pat_q + CNT_W'(1) : pat_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bits_q  <= '0;
      d_q     <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      hist_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
    end
  end
  assign bus.ready_o   = state_q == IDLE;
  assign bus.d_o       = d_q;
  assign bus.valid_o   = valid_q;
  assign bus.done_o    = done_q;
  assign bus.pat_cnt_o = pat_q;
endmodule

// File: tb/tb_pattern_ser_tx.sv
// tb_pattern_ser_tx: table, directed and random checks of pattern_ser_tx against a queue-based model
module tb_pattern_ser_tx;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pattern_ser_tx_if #(.WIDTH(W), .CNT_W(16)) b0 ();
  pattern_ser_tx_if #(.WIDTH(W), .CNT_W(2))  b1 ();
  assign b1.data_i    = b0.data_i;
  assign b1.load_i    = b0.load_i;
  assign b1.hold_i    = b0.hold_i;
  assign b1.clr_cnt_i = b0.clr_cnt_i;
  pattern_ser_tx #(.WIDTH(W), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  pattern_ser_tx #(.WIDTH(W), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .bus(b1));
  int errors = 0;
  int checks = 0;
  bit m_busy, m_d, m_valid, m_done;
  bit rem[$];
  bit hist[$];
  int m_cnt;
  typedef struct {
    bit         ld;
    logic [7:0] dt;
    bit         d;
    bit         v;
    bit         dn;
    bit         rdy;
    int         cnt;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_d = 0; m_valid = 0; m_done = 0; m_cnt = 0;
    rem.delete();
    hist.delete();
  endtask
  task automatic model_edge();
    bit nb, nv;
    nb = m_d; nv = 0; m_done = 0;
    if (!m_busy && b0.load_i) begin
      rem.delete();
      for (int i = W - 1; i >= 0; i--) rem.push_back(b0.data_i[i]);
      m_busy = 1; nb = rem.pop_front(); nv = 1;
    end else if (m_busy && !b0.hold_i) begin
      if (rem.size() == 0) begin
        m_busy = 0; nb = 0; m_done = 1;
      end else begin
        nb = rem.pop_front(); nv = 1;
      end
    end
    m_d = nb; m_valid = nv;
    if (b0.clr_cnt_i) begin
      hist.delete(); m_cnt = 0;
    end else if (nv) begin
      hist.push_back(nb);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4 && hist[0] && !hist[1] && hist[2] && hist[3]) m_cnt++;
    end
  endtask
  task automatic check_model();
    chk("ready0", 32'(b0.ready_o), 32'(!m_busy));
    chk("d0", 32'(b0.d_o), 32'(m_d));
    chk("valid0", 32'(b0.valid_o), 32'(m_valid));
    chk("done0", 32'(b0.done_o), 32'(m_done));
    chk("cnt0", 32'(b0.pat_cnt_o), 32'(m_cnt > 65535 ? 65535 : m_cnt));
    chk("ready1", 32'(b1.ready_o), 32'(!m_busy));
    chk("d1", 32'(b1.d_o), 32'(m_d));
    chk("valid1", 32'(b1.valid_o), 32'(m_valid));
    chk("done1", 32'(b1.done_o), 32'(m_done));
    chk("cnt1", 32'(b1.pat_cnt_o), 32'(m_cnt > 3 ? 3 : m_cnt));
  endtask
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset(); else model_edge();
    @(negedge clk);
    check_model();
  endtask
  task automatic drive(input bit ld, input logic [W-1:0] dt, input bit hd, input bit cl);
    b0.load_i = ld; b0.data_i = dt; b0.hold_i = hd; b0.clr_cnt_i = cl;
    cycle();
  endtask
  initial begin
    logic [7:0] col;
    int n, nv, ndone;
    bit dn;
    tbl[0] = '{1, 8'hB6, 1, 1, 0, 0, 0};
    tbl[1] = '{0, 8'h00, 0, 1, 0, 0, 0};
    tbl[2] = '{0, 8'h00, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 8'h00, 1, 1, 0, 0, 1};
    tbl[4] = '{0, 8'h00, 0, 1, 0, 0, 1};
    tbl[5] = '{0, 8'h00, 1, 1, 0, 0, 1};
    tbl[6] = '{0, 8'h00, 1, 1, 0, 0, 2};
    tbl[7] = '{0, 8'h00, 0, 1, 0, 0, 2};
    tbl[8] = '{0, 8'h00, 0, 0, 1, 1, 2};
    tbl[9] = '{0, 8'h00, 0, 0, 0, 1, 2};
    b0.load_i = 0; b0.data_i = '0; b0.hold_i = 0; b0.clr_cnt_i = 0;
    rst = 1;
    #2 rst = 0;
    #1;
    chk("rst_ready", 32'(b0.ready_o), 1);
    chk("rst_valid", 32'(b0.valid_o), 0);
    chk("rst_d", 32'(b0.d_o), 0);
    chk("rst_done", 32'(b0.done_o), 0);
    chk("rst_cnt", 32'(b0.pat_cnt_o), 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].ld, tbl[i].dt, 0, 0);
      chk("tbl_d", 32'(b0.d_o), 32'(tbl[i].d));
      chk("tbl_valid", 32'(b0.valid_o), 32'(tbl[i].v));
      chk("tbl_done", 32'(b0.done_o), 32'(tbl[i].dn));
      chk("tbl_ready", 32'(b0.ready_o), 32'(tbl[i].rdy));
      chk("tbl_cnt", 32'(b0.pat_cnt_o), 32'(tbl[i].cnt));
    end
    drive(0, 0, 0, 1);
    nv = 0;
    for (int k = 0; k < 18; k++) begin
      drive(k == 0 || k == 9, k < 9 ? 8'h05 : 8'hB0, 0, 0);
      if (b0.valid_o) nv++;
      if (k == 8) chk("xf_done", 32'(b0.done_o), 1);
      if (k == 9) chk("xf_span_cnt", 32'(b0.pat_cnt_o), 1);
    end
    chk("xf_valid_bits", 32'(nv), 16);
    chk("xf_done2", 32'(b0.done_o), 1);
    chk("xf_cnt", 32'(b0.pat_cnt_o), 2);
    col = '0; n = 0; dn = 0;
    for (int k = 0; k < 20 && !dn; k++) begin
      drive(k == 0, 8'hA5, k >= 3 && k < 6, 0);
      n++;
      if (k >= 3 && k < 6) begin
        chk("stall_valid", 32'(b0.valid_o), 0);
        chk("stall_hold_d", 32'(b0.d_o), 1);
      end
      if (b0.valid_o) col = {col[6:0], b0.d_o};
      dn = b0.done_o;
    end
    chk("stall_done_cycle", 32'(n), 12);
    chk("stall_bits", 32'(col), 32'h A5);
    for (int k = 0; k < 4; k++) begin
      drive(k == 0 || k == 2, k == 0 ? 8'hC3 : 8'hFF, 0, 0);
      if (k == 2) begin
        chk("ign_d", 32'(b0.d_o), 0);
        chk("ign_ready", 32'(b0.ready_o), 0);
      end
    end
    #2 rst = 0;
    #1;
    chk("abort_ready", 32'(b0.ready_o), 1);
    chk("abort_valid", 32'(b0.valid_o), 0);
    chk("abort_d", 32'(b0.d_o), 0);
    chk("abort_done", 32'(b0.done_o), 0);
    chk("abort_cnt", 32'(b0.pat_cnt_o), 0);
    model_reset();
    drive(0, 0, 0, 0);
    rst = 1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 0, 0);
      if (b0.done_o || b0.valid_o) ndone++;
    end
    chk("abort_no_resume", 32'(ndone), 0);
    drive(0, 0, 0, 1);
    for (int k = 0; k < 18; k++) drive(k == 0 || k == 9, k < 9 ? 8'hB6 : 8'hDB, 0, 0);
    chk("sat_cnt2", 32'(b1.pat_cnt_o), 3);
    chk("sat_cnt16", 32'(b0.pat_cnt_o), 5);
    drive(1, 8'hB6, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("clr_prio16", 32'(b0.pat_cnt_o), 0);
    chk("clr_prio2", 32'(b1.pat_cnt_o), 0);
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 0);
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pattern_ser_tx.md
PATTERN_SER_TX -- requirements
Module: pattern_ser_tx

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 8, frame width in bits
- CNT_W, 16, pattern-counter width
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- data_i  in  WIDTH  frame to transmit, MSB first
- load_i  in  1  frame load request
- ready_o  out  1  block can accept load_i
- hold_i  in  1  stall; pauses serialization
- clr_cnt_i  in  1  synchronous clear of pattern counter and history
- d_o  out  1  serial data bit
- valid_o  out  1  d_o carries a valid bit this cycle
- done_o  out  1  one-cycle frame-complete pulse
- pat_cnt_o  out  CNT_W  count of overlapping 1011 patterns transmitted
REQ-003 The block SHALL have one clock domain (clk) and an asynchronous, active-low reset (rst); all outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have two states: IDLE and SEND.
REQ-005 In IDLE, ready_o SHALL be 1; in SEND, ready_o SHALL be 0.
REQ-006 A frame SHALL be accepted at a clock edge where load_i=1 and ready_o=1.
- Acceptance captures data_i into the shift register.
- Acceptance loads the bit counter with WIDTH.
- Acceptance moves the FSM to SEND.
REQ-007 load_i while ready_o=0 SHALL be ignored; no frame is queued.
REQ-008 In SEND with hold_i=0, each edge SHALL present the next bit, MSB first, on d_o with valid_o=1, and decrement the bit counter.
- The first bit appears in the cycle after acceptance.
REQ-009 In SEND with hold_i=1, the edge SHALL set valid_o=0 and hold d_o.
- No shift and no counter change.
- Bit order is preserved after release.
REQ-010 After the WIDTH-th valid bit, the next edge SHALL return the FSM to IDLE.
- That edge sets valid_o=0, d_o=0, done_o=1 for exactly one cycle.
- ready_o=1 in that same cycle.
REQ-011 A load_i accepted in the done_o cycle SHALL start the next frame.
- Its first bit appears the following cycle.
- Minimum inter-frame gap is one cycle.
REQ-012 In IDLE (no load), valid_o=0 and d_o=0.
REQ-013 A 3-bit history SHALL hold the last three valid bits transmitted.
- It updates only on valid bits.
- It persists across frames and across hold cycles.
REQ-014 pat_cnt_o SHALL increment at the edge that drives a valid bit 1 while the history is 101.
- Overlapping matches count: stream 1011011 counts 2.
- The new count is visible in the same cycle as the completing bit.
REQ-015 pat_cnt_o SHALL saturate at all-ones and not wrap.
REQ-016 clr_cnt_i=1 SHALL clear pat_cnt_o and the history at the next edge, with priority over a simultaneous increment.
- clr_cnt_i does not affect the frame in progress.

Reset
REQ-017 While rst=0, the block SHALL force the following regardless of clk:
- state=IDLE, ready_o=1
- d_o=0, valid_o=0, done_o=0
- pat_cnt_o=0, history=0, shift register=0, bit counter=0
REQ-018 Reset asserted mid-frame SHALL abort the frame, emit no done_o, and not resume it after release.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset: rst=0 -> ready_o=1, valid_o=0, d_o=0, done_o=0, pat_cnt_o=0 asynchronously.
- Single frame: load 8'b10110110 -> d_o=1,0,1,1,0,1,1,0 with valid_o=1 in cycles 1-8; done_o=1 in cycle 9; pat_cnt_o=2.
- Cross-frame overlap: load 8'h05, then 8'hB0 in the done_o cycle -> 16 contiguous-except-one-gap valid bits; pat_cnt_o=2, including the match spanning the frame boundary.
- Stall: 8'hA5 with hold_i=1 for 3 cycles after bit 3 -> valid_o=0 during those cycles, d_o held; bits 1,0,1,0,0,1,0,1 intact; done_o 12 cycles after load.
- Ignored load and abort: load_i pulsed during SEND -> no effect; rst=0 at bit 4 -> outputs to reset values, no done_o.
- Saturate/clear: CNT_W=2, stream containing 5 matches -> pat_cnt_o=3; clr_cnt_i coincident with a match -> pat_cnt_o=0.
